if_prefetch_buf: RTL and testbench
==================================

// Module: if_prefetch_buf
// PURPOSE
//  Instruction-fetch front end feeding id_stage. Generates sequential PCs and issues
//  requests to instruction memory over a req/gnt/rvalid handshake. Buffers returned
//  words in a DEPTH-entry FIFO and presents {inst, pc} to decode with valid/ready.
//  Redirect (branch/jump) flushes the buffer and discards in-flight stale responses.
// PARAMETERS
//  RESET_PC  64'h8000_0000  first fetch address after reset
//  DEPTH     4              FIFO entries, power of 2, >=2; also max outstanding credit
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  redirect_valid  in   1   1-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   64  new fetch PC, bits[1:0] are 0
//  imem_req        out  1   fetch request
//  imem_addr       out  64  fetch address, word aligned
//  imem_gnt        in   1   request accepted this cycle (when imem_req=1)
//  imem_rvalid     in   1   response valid, in request order, >=1 cycle after gnt
//  imem_rdata      in   32  instruction word
//  id_valid        out  1   id_inst/id_pc valid
//  id_inst         out  32  instruction to decode
//  id_pc           out  64  PC of id_inst
//  id_ready        in   1   decode accepts; transfer when id_valid & id_ready
//  ifu_stall_cnt   out  64  (IFU_PERF_CNT_EN only) cycles with id_ready & !id_valid
// BEHAVIOUR
//  Reset (async assert, sync release): imem_req=0, imem_addr=RESET_PC, id_valid=0,
//   id_inst=0, id_pc=0, FIFO empty, outstanding=0, discard=0, state=BOOT.
//  FSM states BOOT, RUN, FLUSH:
//   BOOT  -> RUN after exactly one cycle; no request is issued in BOOT.
//   RUN   -> FLUSH on redirect_valid when stale outstanding (after this cycle's gnt/rvalid) > 0.
//   RUN   -> RUN on redirect_valid when none are stale.
//   FLUSH -> RUN when discard reaches 0; no new request issued in FLUSH.
//   FLUSH + another redirect_valid: stay FLUSH, fetch_pc <= new redirect_pc.
//  Request rules:
//   Issue only when outstanding + FIFO count < DEPTH (credit); never overflows.
//   Once imem_req=1, req and addr hold until imem_gnt, even across redirect.
//   Gnt increments outstanding, advances fetch_pc by 4.
//   A request pending at redirect is counted stale once granted.
//  Response rules: each rvalid decrements outstanding.
//   discard>0: word dropped, discard-1. Otherwise {rdata, pc} pushed; pc tracked by resp_pc.
//  Redirect: FIFO cleared same edge; discard <= stale outstanding count;
//   fetch_pc and resp_pc <= redirect_pc; id_valid=0 the next cycle.
//  Output: id_* driven from FIFO head (registered storage, combinational read).
//   Minimum latency gnt->rvalid->id_valid is 1 cycle after rvalid.
//   id_inst/id_pc stable while id_valid & !id_ready.
//  Simultaneous events:
//   push+pop when full: both occur, count unchanged.
//   redirect + id handshake: handshake counts as consumed, then flush.
//   redirect + rvalid same cycle: that response counts as stale (dropped).
//  Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  Reset mid-operation: all state cleared; late rvalid after reset release is ignored
//   only if the memory model also resets (memory side shares rst).
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: ifu_stall_cnt port exists. Reset 0, +1 each cycle
//   id_ready=1 & id_valid=0, wraps at 2^64.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  T1 reset release, mem gnt=1, 1-cycle rvalid, id_ready=1 ->
//   first imem_addr=0x8000_0000 in cycle 2; id_pc 0x8000_0000,0x8000_0004,... one per cycle.
//  T2 id_ready=0 for 20 cycles ->
//   at most 4 grants (DEPTH=4), FIFO full, imem_req=0 afterwards; no word lost on release.
//  T3 3 requests outstanding, redirect_pc=0x8000_0100 ->
//   3 responses dropped, FSM FLUSH then RUN, next id_pc=0x8000_0100.
//  T4 imem_gnt held 0 for 5 cycles ->
//   imem_req/imem_addr constant all 5 cycles; redirect in cycle 3 still leaves addr unchanged until gnt.
//  T5 redirect_valid and id handshake same cycle, FIFO count 2 ->
//   handshaken word delivered once; remaining entry discarded; id_valid=0 next cycle.
//  T6 IFU_PERF_CNT_EN, id_ready=1, memory latency 3 cycles ->
//   ifu_stall_cnt increments each empty cycle (first value after BOOT reflects startup bubbles).

Source files
------------

// File: rtl/if_prefetch_buf.sv
// rtl/if_prefetch_buf.sv - instruction prefetch buffer with credit-limited fetch and redirect flush
// Define IFU_PERF_CNT_EN to add the ifu_stall_cnt decode-starvation counter port.
module if_prefetch_buf #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [63:0] id_pc,
  input  logic        id_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] ifu_stall_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;
  state_e state_q, state_d;

  logic             req_q, req_d, pstale_q, pstale_d;
  logic [63:0]      addr_q, addr_d, fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0]      inst_mem [DEPTH];
  logic [63:0]      pc_mem   [DEPTH];

  logic             granted, drop, push, pop, launch, credit_ok;
  logic [CNT_W+1:0] occupied;

  assign granted   = req_q & imem_gnt;
  assign pop       = id_valid & id_ready;
  assign drop      = redirect_valid | (disc_q != '0);
  assign push      = imem_rvalid & ~drop;
  // A pending request reserves its slot so a granted word always has room.
  assign occupied  = (CNT_W+2)'(out_q) + (CNT_W+2)'(cnt_q) + (CNT_W+2)'(req_q);
  assign credit_ok = occupied < (CNT_W+2)'(DEPTH);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    pstale_d   = pstale_q;
    disc_d     = disc_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    out_d      = out_q + CNT_W'(granted) - CNT_W'(imem_rvalid);
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    launch     = 1'b0;

    if (granted && pstale_q) begin
      disc_d   = disc_d + CNT_W'(1);
      pstale_d = 1'b0;
    end
    if (imem_rvalid && disc_q != '0) disc_d = disc_d - CNT_W'(1);
    if (push) begin
      wr_d      = wr_q + PTR_W'(1);
      resp_pc_d = resp_pc_q + 64'd4;
    end
    if (pop) rd_d = rd_q + PTR_W'(1);

    if (granted) req_d = 1'b0;
    launch = (state_q == RUN) && !redirect_valid && (!req_q || imem_gnt) && credit_ok;
    if (launch) begin
      req_d      = 1'b1;
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 64'd4;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   if (disc_d == '0 && !pstale_d) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Everything still in flight after this edge belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      wr_d       = '0;
      rd_d       = '0;
      cnt_d      = '0;
      disc_d     = out_d;
      pstale_d   = req_q & ~imem_gnt;
      state_d    = (out_d != '0 || pstale_d) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      pstale_q   <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      pstale_q   <= pstale_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_q] <= imem_rdata;
      pc_mem[wr_q]   <= resp_pc_q;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = (cnt_q != '0);
  assign id_inst   = id_valid ? inst_mem[rd_q] : 32'd0;
  assign id_pc     = id_valid ? pc_mem[rd_q]   : 64'd0;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= 64'd0;
    else if (id_ready && !id_valid) stall_q <= stall_q + 64'd1;
  end
  assign ifu_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_if_prefetch_buf.sv
// tb/tb_if_prefetch_buf.sv - randomized bench for if_prefetch_buf against an in-order stream model
module tb_if_prefetch_buf;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] ifu_stall_cnt;
  logic [63:0] stall_exp = 64'd0;
`endif

  if_prefetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready)
`ifdef IFU_PERF_CNT_EN
    , .ifu_stall_cnt(ifu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, outstanding = 0, grants = 0, hs = 0, last_due = 0;
  logic [63:0] exp_pc = RESET_PC;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic        prev_req = 0, prev_gnt = 0, prev_valid = 0, prev_ready = 0, prev_redir = 0;
  logic [63:0] prev_addr = 0, prev_pc = 0;
  logic [31:0] prev_inst = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC3A5_5A3C;
  endfunction

  task automatic step(input int gnt_pct, input int rdy_pct, input int redir_pct,
                      input int max_lat, input bit force_redir);
    int lat, due;
    if (prev_req && !prev_gnt) begin
      check("req_hold", imem_req, 1'b1);
      check("addr_hold", imem_addr, prev_addr);
    end
    if (prev_redir) check("valid_after_redirect", id_valid, 1'b0);
    else if (prev_valid && !prev_ready) begin
      check("id_hold_valid", id_valid, 1'b1);
      check("id_hold_pc", id_pc, prev_pc);
      check("id_hold_inst", id_inst, prev_inst);
    end
    check("credit", outstanding <= DEPTH, 1'b1);
`ifdef IFU_PERF_CNT_EN
    check("stall_cnt", ifu_stall_cnt, stall_exp);
`endif
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    imem_rvalid = 1'b0;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else imem_rdata = $urandom;
    id_ready       = ($urandom_range(99) < rdy_pct);
    redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
    if (redirect_valid) redirect_pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};

    if (imem_req && imem_gnt) begin
      lat = $urandom_range(max_lat, 1);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_addr);
      mq_due.push_back(due);
      outstanding++;
      grants++;
    end
    if (imem_rvalid) outstanding--;
    if (id_valid && id_ready) begin
      check("id_pc", id_pc, exp_pc);
      check("id_inst", id_inst, word_of(exp_pc));
      exp_pc = id_pc + 64'd4;
      hs++;
    end
    if (redirect_valid) exp_pc = redirect_pc;
`ifdef IFU_PERF_CNT_EN
    if (id_ready && !id_valid) stall_exp++;
`endif
    prev_req = imem_req;   prev_gnt = imem_gnt;   prev_addr = imem_addr;
    prev_valid = id_valid; prev_ready = id_ready; prev_pc = id_pc;
    prev_inst = id_inst;   prev_redir = redirect_valid;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int g0, h0;
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", id_valid, 1'b0);
    check("rst_inst", id_inst, 32'd0);
    check("rst_pc", id_pc, 64'd0);
`ifdef IFU_PERF_CNT_EN
    check("rst_stall", ifu_stall_cnt, 64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("boot_no_req", imem_req, 1'b0);
    @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RESET_PC);
    cyc = 2;

    repeat (10) step(100, 100, 0, 1, 0);
    h0 = hs;
    repeat (30) step(100, 100, 0, 1, 0);
    check("stream_rate", hs - h0, 30);

    repeat (1500) step(70, 70, 4, 3, 0);

    g0 = grants;
    repeat (40) step(100, 0, 0, 3, 0);
    check("stalled_grants_le_depth", (grants - g0) <= DEPTH, 1'b1);
    check("stalled_req_off", imem_req, 1'b0);
    check("stalled_drained", outstanding, 0);
    repeat (20) step(100, 100, 0, 1, 0);

    check("req_before_gnt_hold", imem_req, 1'b1);
    repeat (2) step(0, 100, 0, 1, 0);
    step(0, 100, 0, 1, 1);
    repeat (5) step(0, 100, 0, 1, 0);
    repeat (20) step(100, 100, 0, 2, 0);

    repeat (500) step(60, 60, 10, 3, 0);

    h0 = hs;
    repeat (40) step(100, 100, 0, 3, 0);
    check("drain_progress", (hs - h0) >= 10, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
